// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the IEEE754 significand multiplier
// and the rounding stage that consumes its output.
package fp_mult_pkg;

    localparam int FRAC_W_DEF = 23;
    localparam int BPC_DEF    = 1;
    localparam int M          = FRAC_W_DEF + 1;
    localparam int ITER       = M / BPC_DEF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    typedef struct packed {
        logic [M-1:0] mant;
        logic         guard;
        logic         sticky;
        logic         norm;
    } norm_t;

    // Left-justify the product so mant always starts at the top bit.
    function automatic norm_t norm_split(input logic [2*M-1:0] prod);
        norm_t            r;
        logic [2*M-1:0]   sh;
        sh       = prod[2*M-1] ? prod : (prod << 1);
        r.mant   = sh[2*M-1:M];
        r.guard  = sh[M-1];
        r.sticky = |sh[M-2:0];
        r.norm   = prod[2*M-1];
        return r;
    endfunction

endpackage

// File: rtl/seq_mant_mult_ctrl.sv
// Sequencer for the shift-add multiplier: state, iteration count
// and the input/output valid-ready handshakes.
module seq_mant_mult_ctrl
    import fp_mult_pkg::*;
#(
    parameter int N_ITER = 24,
    parameter int CW     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load,
    output logic step
);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;

    // Ready is held low for as long as reset is asserted.
    assign in_ready  = rdy_q & ~rst;
    assign out_valid = vld_q;
    assign load      = in_valid & in_ready;
    assign step      = (state_q == CALC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_ITER - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                rdy_d   = 1'b1;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/seq_mant_mult.sv
// Sequential shift-add significand multiplier retiring BPC multiplier
// bits per cycle, with normalised mantissa/guard/sticky outputs.
module seq_mant_mult
    import fp_mult_pkg::*;
#(
    parameter int FRAC_W = 23,
    parameter int BPC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic              a_hid,
    input  logic [FRAC_W-1:0] b_frac,
    input  logic              b_hid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*FRAC_W+1:0] prod,
    output logic [FRAC_W:0]   mant,
    output logic              guard,
    output logic              sticky,
    output logic              norm,
    output logic              zero
);

    localparam int SW     = FRAC_W + 1;
    localparam int N_ITER = SW / BPC;
    localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) ||
        (SW % BPC) != 0 || SW <= BPC || SW < 3) begin : g_bad_cfg
        $error("seq_mant_mult: illegal FRAC_W/BPC combination");
    end

    logic          load;
    logic          step;
    logic [SW-1:0] a_q, a_d;
    logic [SW-1:0] b_q, b_d;
    logic [SW-1:0] p_q, p_d;
    logic [SW+BPC-1:0] sum;
    logic [2*SW-1:0]   prod_w;
    logic [2*SW-1:0]   prod_sh;
    logic              nrm;

    seq_mant_mult_ctrl #(
        .N_ITER (N_ITER),
        .CW     (CW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load      (load),
        .step      (step)
    );

    // Low BPC bits of A select the partial product; A's vacated top
    // bits collect the finished low product bits.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        sum = (SW+BPC)'(p_q)
            + (SW+BPC)'(a_q[BPC-1:0]) * (SW+BPC)'(b_q);
        if (load) begin
            a_d = {a_hid, a_frac};
            b_d = {b_hid, b_frac};
            p_d = '0;
        end else if (step) begin
            {p_d, a_d} = {sum, a_q[SW-1:BPC]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    always_comb begin
        prod_w  = {p_q, a_q};
        nrm     = prod_w[2*SW-1];
        prod_sh = nrm ? prod_w : (prod_w << 1);
        prod    = '0;
        mant    = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        norm    = 1'b0;
        zero    = 1'b0;
        if (out_valid) begin
            prod   = prod_w;
            mant   = prod_sh[2*SW-1:SW];
            guard  = prod_sh[SW-1];
            sticky = |prod_sh[SW-2:0];
            norm   = nrm;
            zero   = (prod_w == '0);
        end
    end

endmodule

// File: tb/tb_seq_mant_mult.sv
// Scoreboard bench for seq_mant_mult: default build plus a BPC=4 copy.
module tb_seq_mant_mult;

    typedef struct {
        logic [47:0] prod;
        logic [23:0] mant;
        logic        guard;
        logic        sticky;
        logic        norm;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [22:0] a_frac = '0;
    logic        a_hid = 1'b0;
    logic [22:0] b_frac = '0;
    logic        b_hid = 1'b0;
    logic        in_ready, out_valid;
    logic [47:0] prod;
    logic [23:0] mant;
    logic        guard, sticky, norm, zero;

    logic        in_valid4 = 1'b0;
    logic        out_ready4 = 1'b1;
    logic        in_ready4, out_valid4;
    logic [47:0] prod4;
    logic [23:0] mant4;
    logic        guard4, sticky4, norm4, zero4;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_mant_mult #(.FRAC_W(23), .BPC(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_frac(a_frac), .a_hid(a_hid),
        .b_frac(b_frac), .b_hid(b_hid),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .mant(mant), .guard(guard),
        .sticky(sticky), .norm(norm), .zero(zero)
    );

    seq_mant_mult #(.FRAC_W(23), .BPC(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a_frac(a_frac), .a_hid(a_hid),
        .b_frac(b_frac), .b_hid(b_hid),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .prod(prod4), .mant(mant4), .guard(guard4),
        .sticky(sticky4), .norm(norm4), .zero(zero4)
    );

    function automatic exp_t model(input logic [22:0] a, input logic ah,
                                   input logic [22:0] b, input logic bh);
        exp_t        e;
        logic [47:0] p;
        p = 48'({ah, a}) * 48'({bh, b});
        e.prod = p;
        e.norm = p[47];
        if (p[47]) begin
            e.mant   = p[47:24];
            e.guard  = p[23];
            e.sticky = |p[22:0];
        end else begin
            e.mant   = p[46:23];
            e.guard  = p[22];
            e.sticky = |p[21:0];
        end
        e.zero = (p == 48'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [22:0] a, input logic ah,
                          input logic [22:0] b, input logic bh,
                          input exp_t e, input int hold, input bit poke,
                          input string nm);
        int          n;
        exp_t        x;
        logic [47:0] hp;
        logic [23:0] hm;
        logic [3:0]  hf;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s ready_timeout in_ready=%b want 1", nm, in_ready);
            return;
        end
        a_frac = a; a_hid = ah; b_frac = b; b_hid = bh;
        in_valid = 1'b1;
        sb.push_back(e);
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        a_frac = 23'($urandom); b_frac = 23'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            if (poke) begin
                in_valid = 1'b1;
                a_frac = 23'($urandom);
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_ready got=%b want 0", nm, in_ready);
                end
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL %s latency got=%0d want 24", nm, n);
        end
        if (!out_valid) return;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got=0 want 1", nm);
            return;
        end
        x = sb.pop_front();
        checks += 6;
        if (prod !== x.prod) begin
            errors++;
            $display("FAIL %s prod got=%h want %h", nm, prod, x.prod);
        end
        if (mant !== x.mant) begin
            errors++;
            $display("FAIL %s mant got=%h want %h", nm, mant, x.mant);
        end
        if (guard !== x.guard) begin
            errors++;
            $display("FAIL %s guard got=%b want %b", nm, guard, x.guard);
        end
        if (sticky !== x.sticky) begin
            errors++;
            $display("FAIL %s sticky got=%b want %b", nm, sticky, x.sticky);
        end
        if (norm !== x.norm) begin
            errors++;
            $display("FAIL %s norm got=%b want %b", nm, norm, x.norm);
        end
        if (zero !== x.zero) begin
            errors++;
            $display("FAIL %s zero got=%b want %b", nm, zero, x.zero);
        end
        hp = prod; hm = mant; hf = {guard, sticky, norm, zero};
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (!out_valid || in_ready || prod !== hp || mant !== hm ||
                {guard, sticky, norm, zero} !== hf) begin
                errors++;
                $display("FAIL %s hold%0d vld=%b rdy=%b prod=%h want vld=1 rdy=0 prod=%h",
                         nm, i, out_valid, in_ready, prod, hp);
            end
        end
        out_ready = 1'b1;
        tick();
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drop_valid got=%b want 0", nm, out_valid);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_back got=%b want 1", nm, in_ready);
        end
        if (prod !== 48'd0) begin
            errors++;
            $display("FAIL %s prod_idle got=%h want 0", nm, prod);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 4;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready got=%b want 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid got=%b want 0", out_valid);
        end
        if ({prod, mant, guard, sticky, norm, zero} !== 76'd0) begin
            errors++;
            $display("FAIL reset outputs prod=%h mant=%h want 0", prod, mant);
        end
        rst = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got=%b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_products();
        exp_t e;
        e = '{prod:48'h900000000000, mant:24'h900000,
              guard:1'b0, sticky:1'b0, norm:1'b1, zero:1'b0};
        run_op(23'h400000, 1'b1, 23'h400000, 1'b1, e, 0, 1'b0, "p1.5x1.5");
        e = '{prod:48'h400000000000, mant:24'h800000,
              guard:1'b0, sticky:1'b0, norm:1'b0, zero:1'b0};
        run_op(23'h000000, 1'b1, 23'h000000, 1'b1, e, 0, 1'b0, "p1x1");
        e = '{prod:48'hFFFFFE000001, mant:24'hFFFFFE,
              guard:1'b0, sticky:1'b1, norm:1'b1, zero:1'b0};
        run_op(23'h7FFFFF, 1'b1, 23'h7FFFFF, 1'b1, e, 0, 1'b0, "pmax");
    endtask

    task automatic test_zero();
        exp_t e;
        e = '{prod:48'd0, mant:24'd0,
              guard:1'b0, sticky:1'b0, norm:1'b0, zero:1'b1};
        run_op(23'h000000, 1'b0, 23'h5A5A5A, 1'b1, e, 0, 1'b1, "zero");
    endtask

    task automatic test_backpressure();
        run_op(23'h123456, 1'b1, 23'h6789AB, 1'b1,
               model(23'h123456, 1'b1, 23'h6789AB, 1'b1), 10, 1'b0, "bp");
    endtask

    task automatic test_back_to_back();
        logic [22:0] a, b;
        logic        ah, bh;
        for (int i = 0; i < 6; i++) begin
            a = 23'($urandom); b = 23'($urandom);
            ah = (i % 3) != 2;
            bh = (i % 4) != 3;
            run_op(a, ah, b, bh, model(a, ah, b, bh), 0, 1'b0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        a_frac = 23'h7FFFFF; a_hid = 1'b1;
        b_frac = 23'h7FFFFF; b_hid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || prod !== 48'd0) begin
            errors++;
            $display("FAIL midrst during rdy=%b vld=%b prod=%h want 0 0 0",
                     in_ready, out_valid, prod);
        end
        tick();
        rst = 1'b0;
        #1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst after rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        tick();
        run_op(23'h2AAAAA, 1'b1, 23'h555555, 1'b1,
               model(23'h2AAAAA, 1'b1, 23'h555555, 1'b1), 0, 1'b0, "midrst_op");
    endtask

    task automatic test_bpc4();
        int   n;
        exp_t e;
        e = model(23'h7FFFFF, 1'b1, 23'h7FFFFF, 1'b1);
        a_frac = 23'h7FFFFF; a_hid = 1'b1;
        b_frac = 23'h7FFFFF; b_hid = 1'b1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL bpc4 ready got=%b want 1", in_ready4);
        end
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        a_frac = '0; b_frac = '0;
        n = 0;
        while (!out_valid4 && n < 100) begin
            tick();
            n++;
        end
        checks += 5;
        if (n !== 6) begin
            errors++;
            $display("FAIL bpc4 latency got=%0d want 6", n);
        end
        if (prod4 !== e.prod) begin
            errors++;
            $display("FAIL bpc4 prod got=%h want %h", prod4, e.prod);
        end
        if (mant4 !== e.mant) begin
            errors++;
            $display("FAIL bpc4 mant got=%h want %h", mant4, e.mant);
        end
        if ({guard4, sticky4, norm4, zero4} !==
            {e.guard, e.sticky, e.norm, e.zero}) begin
            errors++;
            $display("FAIL bpc4 flags got=%b%b%b%b want %b%b%b%b",
                     guard4, sticky4, norm4, zero4,
                     e.guard, e.sticky, e.norm, e.zero);
        end
        tick();
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL bpc4 handshake vld=%b rdy=%b want 0 1",
                     out_valid4, in_ready4);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_bpc4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
